// File: rtl/reg_csr_file.sv
// Register file plus machine CSR file: 32 GPRs, six machine CSRs, with trap capture into mepc/mcause.
// Optional mcycle/minstret counters are built when CSR_COUNTER_EN is defined.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef CSR_number_WIDTH
`define CSR_number_WIDTH 12
`endif

module reg_csr_file (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         W_need_dstE_i,
  input  logic [4:0]                   W_dstE_i,
  input  logic [`XLEN-1:0]             W_data_i,
  input  logic                         W_need_CSR_i,
  input  logic [`CSR_number_WIDTH-1:0] W_csr_addr_i,
  input  logic [`XLEN-1:0]             W_csr_valE_i,
  input  logic                         W_retire_i,
  input  logic                         W_trap_i,
  input  logic [`XLEN-1:0]             W_trap_pc_i,
  input  logic [`XLEN-1:0]             W_trap_cause_i,
  input  logic [4:0]                   D_rs1_i,
  input  logic [4:0]                   D_rs2_i,
  input  logic [`CSR_number_WIDTH-1:0] D_csr_read_addr_i,
  output logic [`XLEN-1:0]             D_rs1_data_o,
  output logic [`XLEN-1:0]             D_rs2_data_o,
  output logic [`XLEN-1:0]             D_csr_data_o,
  output logic                         D_csr_illegal_o,
  output logic [`XLEN-1:0]             mtvec_o
);

  localparam int XL = `XLEN;
  localparam int CW = `CSR_number_WIDTH;

  localparam logic [CW-1:0] ADDR_MSTATUS  = CW'('h300);
  localparam logic [CW-1:0] ADDR_MTVEC    = CW'('h305);
  localparam logic [CW-1:0] ADDR_MSCRATCH = CW'('h340);
  localparam logic [CW-1:0] ADDR_MEPC     = CW'('h341);
  localparam logic [CW-1:0] ADDR_MCAUSE   = CW'('h342);
  localparam logic [CW-1:0] ADDR_MTVAL    = CW'('h343);
`ifdef CSR_COUNTER_EN
  localparam logic [CW-1:0] ADDR_MCYCLE   = CW'('hB00);
  localparam logic [CW-1:0] ADDR_MINSTRET = CW'('hB02);
`endif

  logic [XL-1:0] gpr_reg [32];
  logic [XL-1:0] mstatus_reg;
  logic [XL-1:0] mtvec_reg;
  logic [XL-1:0] mscratch_reg;
  logic [XL-1:0] mepc_reg;
  logic [XL-1:0] mcause_reg;
  logic [XL-1:0] mtval_reg;

  logic gpr_we;
  logic csr_we;

  // A committing trap squashes every architectural side effect of the same instruction.
  assign gpr_we = W_need_dstE_i && !W_trap_i && (W_dstE_i != 5'd0);
  assign csr_we = W_need_CSR_i && !W_trap_i;

  // Entry 0 is never written, so x0 stays zero after reset as well.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        gpr_reg[i] <= '0;
      end
    end else if (gpr_we) begin
      gpr_reg[W_dstE_i] <= W_data_i;
    end
  end

  logic [4:0]    rd_idx  [2];
  logic [XL-1:0] rd_data [2];
  assign rd_idx[0] = D_rs1_i;
  assign rd_idx[1] = D_rs2_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_gpr_rd
      assign rd_data[gi] = (rd_idx[gi] == 5'd0) ? '0 : gpr_reg[rd_idx[gi]];
    end
  endgenerate

  assign D_rs1_data_o = rd_data[0];
  assign D_rs2_data_o = rd_data[1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mstatus_reg  <= '0;
      mtvec_reg    <= '0;
      mscratch_reg <= '0;
      mepc_reg     <= '0;
      mcause_reg   <= '0;
      mtval_reg    <= '0;
    end else if (W_trap_i) begin
      mepc_reg   <= {W_trap_pc_i[XL-1:2], 2'b00};
      mcause_reg <= W_trap_cause_i;
    end else if (csr_we) begin
      case (W_csr_addr_i)
        ADDR_MSTATUS:  mstatus_reg  <= W_csr_valE_i;
        ADDR_MTVEC:    mtvec_reg    <= {W_csr_valE_i[XL-1:2], 2'b00};
        ADDR_MSCRATCH: mscratch_reg <= W_csr_valE_i;
        ADDR_MEPC:     mepc_reg     <= {W_csr_valE_i[XL-1:2], 2'b00};
        ADDR_MCAUSE:   mcause_reg   <= W_csr_valE_i;
        ADDR_MTVAL:    mtval_reg    <= W_csr_valE_i;
        default: ;
      endcase
    end
  end

`ifdef CSR_COUNTER_EN
  logic [XL-1:0] mcycle_reg;
  logic [XL-1:0] minstret_reg;

  // A software write takes priority over the increment in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcycle_reg   <= '0;
      minstret_reg <= '0;
    end else begin
      if (csr_we && (W_csr_addr_i == ADDR_MCYCLE)) begin
        mcycle_reg <= W_csr_valE_i;
      end else begin
        mcycle_reg <= mcycle_reg + 1'b1;
      end
      if (csr_we && (W_csr_addr_i == ADDR_MINSTRET)) begin
        minstret_reg <= W_csr_valE_i;
      end else if (W_retire_i && !W_trap_i) begin
        minstret_reg <= minstret_reg + 1'b1;
      end
    end
  end
`endif

  always_comb begin
    D_csr_data_o    = '0;
    D_csr_illegal_o = 1'b0;
    case (D_csr_read_addr_i)
      ADDR_MSTATUS:  D_csr_data_o = mstatus_reg;
      ADDR_MTVEC:    D_csr_data_o = mtvec_reg;
      ADDR_MSCRATCH: D_csr_data_o = mscratch_reg;
      ADDR_MEPC:     D_csr_data_o = mepc_reg;
      ADDR_MCAUSE:   D_csr_data_o = mcause_reg;
      ADDR_MTVAL:    D_csr_data_o = mtval_reg;
`ifdef CSR_COUNTER_EN
      ADDR_MCYCLE:   D_csr_data_o = mcycle_reg;
      ADDR_MINSTRET: D_csr_data_o = minstret_reg;
`endif
      default:       D_csr_illegal_o = 1'b1;
    endcase
  end

  assign mtvec_o = mtvec_reg;

endmodule

// File: tb/tb_reg_csr_file.sv
// Directed self-checking bench for reg_csr_file; counter checks follow CSR_COUNTER_EN.
`ifndef XLEN
`define XLEN 32
`endif

module tb_reg_csr_file;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             W_need_dstE_i;
  logic [4:0]       W_dstE_i;
  logic [`XLEN-1:0] W_data_i;
  logic             W_need_CSR_i;
  logic [11:0]      W_csr_addr_i;
  logic [`XLEN-1:0] W_csr_valE_i;
  logic             W_retire_i;
  logic             W_trap_i;
  logic [`XLEN-1:0] W_trap_pc_i;
  logic [`XLEN-1:0] W_trap_cause_i;
  logic [4:0]       D_rs1_i;
  logic [4:0]       D_rs2_i;
  logic [11:0]      D_csr_read_addr_i;
  logic [`XLEN-1:0] D_rs1_data_o;
  logic [`XLEN-1:0] D_rs2_data_o;
  logic [`XLEN-1:0] D_csr_data_o;
  logic             D_csr_illegal_o;
  logic [`XLEN-1:0] mtvec_o;

  int test_cnt = 0;
  int fail_cnt = 0;

  reg_csr_file dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .W_need_dstE_i     (W_need_dstE_i),
    .W_dstE_i          (W_dstE_i),
    .W_data_i          (W_data_i),
    .W_need_CSR_i      (W_need_CSR_i),
    .W_csr_addr_i      (W_csr_addr_i),
    .W_csr_valE_i      (W_csr_valE_i),
    .W_retire_i        (W_retire_i),
    .W_trap_i          (W_trap_i),
    .W_trap_pc_i       (W_trap_pc_i),
    .W_trap_cause_i    (W_trap_cause_i),
    .D_rs1_i           (D_rs1_i),
    .D_rs2_i           (D_rs2_i),
    .D_csr_read_addr_i (D_csr_read_addr_i),
    .D_rs1_data_o      (D_rs1_data_o),
    .D_rs2_data_o      (D_rs2_data_o),
    .D_csr_data_o      (D_csr_data_o),
    .D_csr_illegal_o   (D_csr_illegal_o),
    .mtvec_o           (mtvec_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [`XLEN-1:0] got, input logic [`XLEN-1:0] exp);
    test_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_w();
    W_need_dstE_i = 1'b0;
    W_need_CSR_i  = 1'b0;
    W_retire_i    = 1'b0;
    W_trap_i      = 1'b0;
  endtask

  task automatic gpr_wr(input logic [4:0] idx, input logic [`XLEN-1:0] val);
    W_need_dstE_i = 1'b1;
    W_dstE_i      = idx;
    W_data_i      = val;
    tick();
    idle_w();
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] addr, input logic [`XLEN-1:0] val);
    W_need_CSR_i = 1'b1;
    W_csr_addr_i = addr;
    W_csr_valE_i = val;
    tick();
    idle_w();
    #1;
  endtask

  task automatic csr_rd(input string tag, input logic [11:0] addr,
                        input logic [`XLEN-1:0] exp, input logic exp_ill);
    D_csr_read_addr_i = addr;
    #1;
    check({tag, "_data"}, D_csr_data_o, exp);
    check({tag, "_ill"}, {{(`XLEN-1){1'b0}}, D_csr_illegal_o}, {{(`XLEN-1){1'b0}}, exp_ill});
  endtask

  initial begin
    rst_i = 1'b1;
    idle_w();
    W_dstE_i = 5'd0; W_data_i = '0; W_csr_addr_i = '0; W_csr_valE_i = '0;
    W_trap_pc_i = '0; W_trap_cause_i = '0;
    D_rs1_i = 5'd5; D_rs2_i = 5'd0; D_csr_read_addr_i = 12'h305;

    // Writes presented during reset must be lost.
    W_need_dstE_i = 1'b1; W_dstE_i = 5'd5; W_data_i = 32'h0000_0055;
    W_need_CSR_i = 1'b1; W_csr_addr_i = 12'h305; W_csr_valE_i = 32'h0000_1000;
    tick(); tick();
    check("rst_rs1", D_rs1_data_o, 32'h0);
    check("rst_mtvec_o", mtvec_o, 32'h0);
    csr_rd("rst_mtvec", 12'h305, 32'h0, 1'b0);
    idle_w();
    #2 rst_i = 1'b0;
    tick();
    check("post_rst_x5", D_rs1_data_o, 32'h0);

    // Same-cycle read sees old value, next cycle sees new.
    W_need_dstE_i = 1'b1; W_dstE_i = 5'd5; W_data_i = 32'hDEAD_BEEF;
    #1 check("x5_same_cycle", D_rs1_data_o, 32'h0);
    tick(); idle_w();
    check("x5_next_cycle", D_rs1_data_o, 32'hDEAD_BEEF);

    gpr_wr(5'd0, 32'h0000_1234);
    D_rs2_i = 5'd0; #1;
    check("x0_reads_zero", D_rs2_data_o, 32'h0);
    gpr_wr(5'd31, 32'hA5A5_5A5A);
    D_rs2_i = 5'd31; #1;
    check("x31", D_rs2_data_o, 32'hA5A5_5A5A);
    check("x5_kept", D_rs1_data_o, 32'hDEAD_BEEF);

    csr_wr(12'h305, 32'h8000_0007);
    check("mtvec_o", mtvec_o, 32'h8000_0004);
    csr_rd("mtvec", 12'h305, 32'h8000_0004, 1'b0);

    csr_wr(12'h340, 32'h1111_2222);
    csr_rd("mscratch", 12'h340, 32'h1111_2222, 1'b0);
    gpr_wr(5'd7, 32'h0000_0077);

    // Trap suppresses same-cycle GPR and CSR writes.
    W_trap_i = 1'b1; W_trap_pc_i = 32'h0000_0103; W_trap_cause_i = 32'h2;
    W_need_dstE_i = 1'b1; W_dstE_i = 5'd7; W_data_i = 32'h0000_0099;
    W_need_CSR_i = 1'b1; W_csr_addr_i = 12'h340; W_csr_valE_i = 32'h0000_FFFF;
    W_retire_i = 1'b1;
    tick(); idle_w();
    csr_rd("trap_mepc", 12'h341, 32'h0000_0100, 1'b0);
    csr_rd("trap_mcause", 12'h342, 32'h2, 1'b0);
    csr_rd("trap_mscratch", 12'h340, 32'h1111_2222, 1'b0);
    D_rs1_i = 5'd7; #1;
    check("trap_x7", D_rs1_data_o, 32'h0000_0077);

    csr_wr(12'h341, 32'h0000_2003);
    csr_rd("mepc_wr", 12'h341, 32'h0000_2000, 1'b0);
    csr_wr(12'h343, 32'h0000_CAFE);
    csr_rd("mtval", 12'h343, 32'h0000_CAFE, 1'b0);
    csr_wr(12'h300, 32'h0000_1888);
    csr_rd("mstatus", 12'h300, 32'h0000_1888, 1'b0);
    csr_wr(12'h342, 32'h8000_000B);
    csr_rd("mcause_wr", 12'h342, 32'h8000_000B, 1'b0);

    csr_wr(12'h7C0, 32'h1234_5678);
    csr_rd("unimpl_7c0", 12'h7C0, 32'h0, 1'b1);
    csr_rd("mstatus_kept", 12'h300, 32'h0000_1888, 1'b0);

`ifdef CSR_COUNTER_EN
    csr_wr(12'hB00, 32'hFFFF_FFFF);
    #0;
    D_csr_read_addr_i = 12'hB00;
    // csr_wr already advanced one cycle; value is all-ones until the next edge.
    #1 check("mcycle_all_ones", D_csr_data_o, 32'hFFFF_FFFF);
    tick();
    csr_rd("mcycle_wrap", 12'hB00, 32'h0, 1'b0);
    W_need_CSR_i = 1'b1; W_csr_addr_i = 12'hB02; W_csr_valE_i = 32'h5;
    W_retire_i = 1'b1;
    tick(); idle_w();
    csr_rd("minstret_wr_wins", 12'hB02, 32'h5, 1'b0);
    W_retire_i = 1'b1;
    tick();
    W_trap_i = 1'b1; W_trap_pc_i = 32'h0; W_trap_cause_i = 32'h3;
    tick(); idle_w();
    csr_rd("minstret_inc", 12'hB02, 32'h6, 1'b0);
`else
    csr_wr(12'hB00, 32'h0000_0010);
    csr_rd("no_mcycle", 12'hB00, 32'h0, 1'b1);
    csr_rd("no_minstret", 12'hB02, 32'h0, 1'b1);
`endif

    // Asynchronous reset between edges clears outputs before the next edge.
    D_rs1_i = 5'd5; D_csr_read_addr_i = 12'h341;
    #1 check("pre_arst_x5", D_rs1_data_o, 32'hDEAD_BEEF);
    #1 rst_i = 1'b1;
    #1;
    check("arst_x5", D_rs1_data_o, 32'h0);
    check("arst_mtvec_o", mtvec_o, 32'h0);
    check("arst_mepc", D_csr_data_o, 32'h0);
    #1 rst_i = 1'b0;
    gpr_wr(5'd5, 32'h0000_0042);
    check("resume_x5", D_rs1_data_o, 32'h0000_0042);
    csr_wr(12'h305, 32'h0000_0103);
    check("resume_mtvec_o", mtvec_o, 32'h0000_0100);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
